controller: RTL and testbench
=============================

Name: controller

Overview:
- Instruction-sequencing state machine for the RISC CPU.
- Drives the program counter's ld_pc/inc_pc and every other datapath strobe: address-mux select, memory rd/wr, IR load, accumulator load, data bus enable.
- Sequences each instruction through a fixed 8-phase cycle, decodes the 3-bit opcode held in the IR and the ALU zero flag, and latches a sticky halt on HLT.

Parameters:
- OPCODE_WIDTH, 3, opcode field width (from `def.v`; fixed encoding set below).
- PHASE_WIDTH, 3, phase counter width; 8 phases, wraps 7 -> 0.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  asynchronous, active-low reset; phase=INST_ADDR, halted=0 while low.
- opcode  input  OPCODE_WIDTH  opcode from instruction register; valid from IDLE through STORE.
- zero  input  1  accumulator-zero flag from ALU; sampled combinationally in ALU_OP.
- sel  output  1  address mux select: 1 = PC, 0 = IR operand address.
- rd  output  1  memory read strobe.
- wr  output  1  memory write strobe.
- ld_ir  output  1  instruction register load.
- ld_ac  output  1  accumulator load.
- inc_pc  output  1  program counter increment.
- ld_pc  output  1  program counter load (branch target from IR).
- data_e  output  1  accumulator drives data bus.
- halt  output  1  processor halted indication.
- phase  output  PHASE_WIDTH  current phase, for debug/bench.

Behaviour:
- Opcodes: HLT=000, SKZ=001, ADD=010, AND=011, XOR=100, LDA=101, STO=110, JMP=111.
- ALUOP = ADD|AND|XOR|LDA.
- Phases, in order: INST_ADDR=0, INST_FETCH=1, INST_LOAD=2, IDLE=3, OP_ADDR=4, OP_FETCH=5, ALU_OP=6, STORE=7.
- Phase advances by 1 every clock, 7 -> 0, unless halted.
- Outputs are combinational decode of the registered phase, opcode and zero. No output registers; one-phase granularity.
- Output decode per phase (any output not listed is 0):
  - INST_ADDR: sel=1.
  - INST_FETCH: sel=1, rd=1.
  - INST_LOAD: sel=1, rd=1, ld_ir=1.
  - IDLE: sel=1, rd=1, ld_ir=1.
  - OP_ADDR: inc_pc=1; halt=1 if opcode==HLT.
  - OP_FETCH: rd=ALUOP.
  - ALU_OP: rd=ALUOP; inc_pc=(opcode==SKZ && zero); ld_pc=(opcode==JMP); data_e=(opcode==STO).
  - STORE: rd=ALUOP; ld_ac=ALUOP; ld_pc=(opcode==JMP); wr=(opcode==STO); data_e=(opcode==STO).
- Halt:
  - The posedge that ends OP_ADDR with opcode==HLT sets halted=1.
  - While halted: phase frozen at OP_FETCH (5); all strobes 0; halt=1.
  - Cleared only by rst.
  - The OP_ADDR inc_pc of the HLT instruction still fires, so PC ends one past HLT.
- SKZ with zero=0: no extra increment. zero is only significant in ALU_OP.
- JMP asserts ld_pc in two consecutive phases; PC load has priority over increment, so a coincident inc_pc is ignored.
- Reset values (rst low, asynchronous): phase=0, halted=0, hence sel=1, all other strobes 0, halt=0.
- Reset asserted mid-instruction aborts immediately; the first phase after release is INST_ADDR.
- Unknown/X opcode is not decoded specially; all encodings are defined.

Decomposition:
- Shared `def.v` gains:
  - OPCODE_WIDTH and PHASE_WIDTH.
  - `define constants for the eight opcodes and eight phase encodings.
- Sub-module phase_counter: 3-bit wrapping counter with active-low async reset and enable.
  - enable = !halted.
  - Controller top holds the halted flag and the output decode.

Test Plan:
- Reset then free-run, opcode=ADD (010), zero=0:
  - phase sequence 0..7 repeats.
  - rd high in phases 1,2,3,5,6,7; ld_ir in 2,3; inc_pc only in 4; ld_ac only in 7.
- opcode=SKZ (001):
  - zero=1: inc_pc high in phases 4 and 6 (two increments per instruction).
  - zero=0: inc_pc high only in phase 4.
- opcode=JMP (111): ld_pc high in phases 6 and 7; rd, wr, data_e stay 0 in phases 5-7.
- opcode=STO (110): data_e high in 6 and 7; wr high only in 7; rd and ld_ac 0 in 5-7.
- opcode=HLT (000):
  - halt rises in phase 4.
  - After the next edge, phase stays 5 for 20 cycles with halt=1 and all strobes 0.
  - rst pulse low returns phase=0, halt=0, sel=1.
- Asynchronous rst asserted mid-phase 6 (no clock edge): phase reads 0 immediately; after release, 8 normal phases follow.

Source files
------------

// File: rtl/controller_pkg.sv
// Shared definitions for the instruction-sequencing controller:
// opcode and phase encodings plus a small opcode-class helper.
package controller_pkg;

  localparam int unsigned OPCODE_WIDTH = 3;
  localparam int unsigned PHASE_WIDTH  = 3;

  typedef enum logic [OPCODE_WIDTH-1:0] {
    OP_HLT = 3'b000,
    OP_SKZ = 3'b001,
    OP_ADD = 3'b010,
    OP_AND = 3'b011,
    OP_XOR = 3'b100,
    OP_LDA = 3'b101,
    OP_STO = 3'b110,
    OP_JMP = 3'b111
  } opcode_e;

  typedef enum logic [PHASE_WIDTH-1:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } phase_e;

  // Instructions that read an operand from memory into the accumulator.
  function automatic logic is_aluop(opcode_e op);
    return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
  endfunction

endpackage

// File: rtl/controller_if.sv
// Controller <-> datapath strobe bundle. The master side is the
// controller; the slave side is the datapath that supplies opcode/zero.
interface controller_if;
  import controller_pkg::*;

  logic [OPCODE_WIDTH-1:0] opcode;
  logic                    zero;
  logic                    sel;
  logic                    rd;
  logic                    wr;
  logic                    ld_ir;
  logic                    ld_ac;
  logic                    inc_pc;
  logic                    ld_pc;
  logic                    data_e;
  logic                    halt;
  logic [PHASE_WIDTH-1:0]  phase;

  modport master (
    input  opcode, zero,
    output sel, rd, wr, ld_ir, ld_ac, inc_pc, ld_pc, data_e, halt, phase
  );

  modport slave (
    output opcode, zero,
    input  sel, rd, wr, ld_ir, ld_ac, inc_pc, ld_pc, data_e, halt, phase
  );

endinterface

// File: rtl/controller_phase_counter.sv
// Eight-phase instruction cycle counter; wraps STORE -> INST_ADDR and
// holds its value while enable is low.
module controller_phase_counter
  import controller_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   en,
  output phase_e phase_o
);

  phase_e state_q, state_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= INST_ADDR;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (en) state_d = phase_e'(state_q + 3'd1);
  end

  assign phase_o = state_q;

endmodule

// File: rtl/controller.sv
// RISC CPU instruction sequencer: steps the phase counter, decodes
// phase/opcode/zero into datapath strobes and holds a sticky halt.
module controller
  import controller_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  controller_if.master bus
);

  phase_e  phase_q;
  opcode_e op;
  logic    alu;
  logic    halted_q, halted_d;
  logic    count_en;
  logic    hlt_now;

  logic sel, rd, wr, ld_ir, ld_ac, inc_pc, ld_pc, data_e, halt;

  assign op       = opcode_e'(bus.opcode);
  assign alu      = is_aluop(op);
  assign count_en = !halted_q;
  assign hlt_now  = (phase_q == OP_ADDR) && (op == OP_HLT);

  controller_phase_counter u_phase (
    .clk     (clk),
    .rst     (rst),
    .en      (count_en),
    .phase_o (phase_q)
  );

  // The counter still advances on the HLT edge, so a halted machine
  // parks in OP_FETCH.
  assign halted_d = halted_q | hlt_now;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) halted_q <= 1'b0;
    else      halted_q <= halted_d;
  end

  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    wr     = 1'b0;
    ld_ir  = 1'b0;
    ld_ac  = 1'b0;
    inc_pc = 1'b0;
    ld_pc  = 1'b0;
    data_e = 1'b0;
    halt   = halted_q;
    if (!halted_q) begin
      unique case (phase_q)
        INST_ADDR: begin
          sel = 1'b1;
        end
        INST_FETCH: begin
          sel = 1'b1;
          rd  = 1'b1;
        end
        INST_LOAD, IDLE: begin
          sel   = 1'b1;
          rd    = 1'b1;
          ld_ir = 1'b1;
        end
        OP_ADDR: begin
          inc_pc = 1'b1;
          halt   = hlt_now;
        end
        OP_FETCH: begin
          rd = alu;
        end
        ALU_OP: begin
          rd     = alu;
          inc_pc = (op == OP_SKZ) && bus.zero;
          ld_pc  = (op == OP_JMP);
          data_e = (op == OP_STO);
        end
        STORE: begin
          rd     = alu;
          ld_ac  = alu;
          ld_pc  = (op == OP_JMP);
          wr     = (op == OP_STO);
          data_e = (op == OP_STO);
        end
        default: ;
      endcase
    end
  end

  assign bus.sel    = sel;
  assign bus.rd     = rd;
  assign bus.wr     = wr;
  assign bus.ld_ir  = ld_ir;
  assign bus.ld_ac  = ld_ac;
  assign bus.inc_pc = inc_pc;
  assign bus.ld_pc  = ld_pc;
  assign bus.data_e = data_e;
  assign bus.halt   = halt;
  assign bus.phase  = phase_q;

endmodule

// File: tb/tb_controller.sv
// Bench for the instruction sequencer: directed and random opcode streams
// compared every cycle against a phase/halt reference model.
module tb_controller;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  int       exp_phase;
  bit       exp_halted;
  bit [2:0] cur_op;
  bit       cur_z;

  controller_if bus ();

  controller dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Expected strobes {sel,rd,wr,ld_ir,ld_ac,inc_pc,ld_pc,data_e,halt}.
  function automatic logic [8:0] ref_out(int p, int op, bit z, bit h);
    bit alu, sel, rd, wr, ld_ir, ld_ac, inc_pc, ld_pc, data_e, halt;
    if (h) return 9'b0_0000_0001;
    alu    = (op >= 2) && (op <= 5);
    sel    = (p <= 3);
    rd     = ((p >= 1) && (p <= 3)) || ((p >= 5) && alu);
    wr     = (op == 6) && (p == 7);
    ld_ir  = (p == 2) || (p == 3);
    ld_ac  = alu && (p == 7);
    inc_pc = (p == 4) || ((p == 6) && (op == 1) && z);
    ld_pc  = (op == 7) && (p >= 6);
    data_e = (op == 6) && (p >= 6);
    halt   = (p == 4) && (op == 0);
    return {sel, rd, wr, ld_ir, ld_ac, inc_pc, ld_pc, data_e, halt};
  endfunction

  function automatic logic [8:0] dut_out();
    return {bus.sel, bus.rd, bus.wr, bus.ld_ir, bus.ld_ac,
            bus.inc_pc, bus.ld_pc, bus.data_e, bus.halt};
  endfunction

  // One clock: advance the model on the edge, then apply the next inputs.
  task automatic tick(input bit [2:0] new_op, input bit new_z);
    @(posedge clk);
    #1;
    if (rst && !exp_halted) begin
      if (exp_phase == 4 && cur_op == 3'd0) exp_halted = 1'b1;
      exp_phase = (exp_phase + 1) % 8;
    end
    cur_op     = new_op;
    cur_z      = new_z;
    bus.opcode = new_op;
    bus.zero   = new_z;
    #1;
  endtask

  task automatic test_reset();
    logic [8:0] exp;
    rst = 1'b0;
    cur_op = 3'd2; cur_z = 1'b0;
    bus.opcode = cur_op; bus.zero = cur_z;
    exp_phase = 0; exp_halted = 1'b0;
    #13;
    checks++;
    if (bus.phase !== 3'd0) begin
      failures++;
      $display("FAIL reset_phase got=%0d exp=0", bus.phase);
    end
    exp = 9'b1_0000_0000;
    checks++;
    if (dut_out() !== exp) begin
      failures++;
      $display("FAIL reset_strobes got=%b exp=%b", dut_out(), exp);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic run_checked(input string name, input bit [2:0] op, input int n,
                             input bit rand_z, input bit fixed_z);
    logic [8:0] exp;
    bit z;
    for (int i = 0; i < n; i++) begin
      z = rand_z ? bit'($urandom_range(0, 1)) : fixed_z;
      tick(op, z);
      checks++;
      if (bus.phase !== 3'(exp_phase)) begin
        failures++;
        $display("FAIL %s_phase cyc=%0d got=%0d exp=%0d", name, i, bus.phase, exp_phase);
      end
      exp = ref_out(exp_phase, int'(cur_op), cur_z, exp_halted);
      checks++;
      if (dut_out() !== exp) begin
        failures++;
        $display("FAIL %s_strobes cyc=%0d ph=%0d op=%0d z=%0d got=%b exp=%b",
                 name, i, exp_phase, cur_op, cur_z, dut_out(), exp);
      end
    end
  endtask

  task automatic test_add();
    run_checked("add", 3'd2, 16, 1'b0, 1'b0);
  endtask

  task automatic test_skz();
    run_checked("skz_z1", 3'd1, 8, 1'b0, 1'b1);
    run_checked("skz_z0", 3'd1, 8, 1'b0, 1'b0);
  endtask

  task automatic test_jmp();
    run_checked("jmp", 3'd7, 8, 1'b1, 1'b0);
  endtask

  task automatic test_sto();
    run_checked("sto", 3'd6, 8, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    logic [8:0] exp;
    bit [2:0] op;
    bit z;
    op = cur_op;
    for (int i = 0; i < 64; i++) begin
      if ((exp_phase + 1) % 8 == 1) op = 3'($urandom_range(1, 7));
      z = bit'($urandom_range(0, 1));
      tick(op, z);
      checks++;
      if (bus.phase !== 3'(exp_phase)) begin
        failures++;
        $display("FAIL rand_phase cyc=%0d got=%0d exp=%0d", i, bus.phase, exp_phase);
      end
      exp = ref_out(exp_phase, int'(cur_op), cur_z, exp_halted);
      checks++;
      if (dut_out() !== exp) begin
        failures++;
        $display("FAIL rand_strobes cyc=%0d ph=%0d op=%0d z=%0d got=%b exp=%b",
                 i, exp_phase, cur_op, cur_z, dut_out(), exp);
      end
    end
  endtask

  task automatic test_async_reset();
    run_checked("pre_async", 3'd2, 6, 1'b0, 1'b0);
    #1;
    rst = 1'b0;
    #1;
    exp_phase = 0; exp_halted = 1'b0;
    checks++;
    if (bus.phase !== 3'd0) begin
      failures++;
      $display("FAIL async_rst_phase got=%0d exp=0", bus.phase);
    end
    checks++;
    if (bus.sel !== 1'b1 || bus.rd !== 1'b0) begin
      failures++;
      $display("FAIL async_rst_strobes got=%b exp=%b", dut_out(), 9'b1_0000_0000);
    end
    @(negedge clk);
    #2;
    rst = 1'b1;
    run_checked("post_async", 3'd2, 8, 1'b0, 1'b0);
  endtask

  task automatic test_halt();
    run_checked("hlt_run", 3'd0, 4, 1'b0, 1'b0);
    checks++;
    if (bus.halt !== 1'b1 || bus.phase !== 3'd4) begin
      failures++;
      $display("FAIL hlt_rise got halt=%0d ph=%0d exp halt=1 ph=4", bus.halt, bus.phase);
    end
    run_checked("hlt_frozen", 3'd2, 21, 1'b1, 1'b0);
    checks++;
    if (bus.phase !== 3'd5 || dut_out() !== 9'b0_0000_0001) begin
      failures++;
      $display("FAIL hlt_parked got ph=%0d strobes=%b exp ph=5 strobes=000000001",
               bus.phase, dut_out());
    end
    #1;
    rst = 1'b0;
    #1;
    exp_phase = 0; exp_halted = 1'b0;
    checks++;
    if (bus.phase !== 3'd0 || dut_out() !== 9'b1_0000_0000) begin
      failures++;
      $display("FAIL hlt_clear got ph=%0d strobes=%b exp ph=0 strobes=100000000",
               bus.phase, dut_out());
    end
    @(negedge clk);
    rst = 1'b1;
    run_checked("post_hlt", 3'd5, 8, 1'b1, 1'b0);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_add();
    test_skz();
    test_jmp();
    test_sto();
    test_random();
    test_async_reset();
    test_halt();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
